sysid_regbank: RTL and testbench

SYSID_REGBANK -- requirements
Module: sysid_regbank

---
 rtl/sysid_regbank_if.sv | 23 ++
 rtl/sysid_regbank.sv | 106 ++++++++++
 tb/tb_sysid_regbank.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sysid_regbank_if.sv
// Avalon-MM slave bundle for the system-ID register bank: one word-addressed
// port with fixed one-cycle read latency and no waitrequest.
interface sysid_regbank_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [31:0]       writedata;
  logic [3:0]        byteenable;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regbank.sv
// System-ID register bank: ID/timestamp/caps, scratch, user words, and an optional
// 64-bit uptime counter with a latched upper word (enabled by SYSID_REGBANK_UPTIME_EN).
module sysid_regbank #(
  parameter logic [31:0]            SYSID_ID        = 32'h0000_0000,
  parameter logic [31:0]            SYSID_TIMESTAMP = 32'd1506524032,
  parameter int                     NUM_USER        = 4,
  parameter logic [32*NUM_USER-1:0] USER_WORDS      = '0,
  parameter int                     ADDR_W          = 4
) (
  input logic            clock,
  input logic            reset,
  sysid_regbank_if.slave bus
);

  localparam logic [ADDR_W-1:0] A_ID      = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_TS      = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_CAPS    = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_SCRATCH = ADDR_W'(3);
  localparam int                USER_BASE = 8;

`ifdef SYSID_REGBANK_UPTIME_EN
  localparam logic              UPTIME_PRESENT = 1'b1;
  localparam logic [ADDR_W-1:0] A_UP_LO        = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_UP_HI        = ADDR_W'(5);
  localparam logic [ADDR_W-1:0] A_CTRL         = ADDR_W'(6);
`else
  localparam logic              UPTIME_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS = {23'd0, UPTIME_PRESENT, 8'(NUM_USER)};

  logic [31:0] scratch_q, scratch_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q;
  logic [31:0] rd_mux;
  int          uidx;

`ifdef SYSID_REGBANK_UPTIME_EN
  logic [63:0] uptime_q, uptime_d;
  logic [31:0] hold_q, hold_d;
  logic        clear;

  always_comb begin
    clear    = bus.write && (bus.address == A_CTRL) && bus.byteenable[0] && bus.writedata[0];
    uptime_d = clear ? 64'd0 : uptime_q + 64'd1;
    // The snapshot takes the pre-edge count, so it pairs with the LO word returned.
    hold_d   = (bus.read && (bus.address == A_UP_LO)) ? uptime_q[63:32] : hold_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime_q <= '0;
      hold_q   <= '0;
    end else begin
      uptime_q <= uptime_d;
      hold_q   <= hold_d;
    end
  end
`endif

  always_comb begin
    scratch_d = scratch_q;
    if (bus.write && (bus.address == A_SCRATCH)) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.byteenable[b]) scratch_d[8*b +: 8] = bus.writedata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    uidx   = int'(bus.address) - USER_BASE;
    case (bus.address)
      A_ID:      rd_mux = SYSID_ID;
      A_TS:      rd_mux = SYSID_TIMESTAMP;
      A_CAPS:    rd_mux = CAPS;
      A_SCRATCH: rd_mux = scratch_q;
`ifdef SYSID_REGBANK_UPTIME_EN
      A_UP_LO:   rd_mux = uptime_q[31:0];
      A_UP_HI:   rd_mux = hold_q;
`endif
      default: begin
        if (uidx >= 0 && uidx < NUM_USER) rd_mux = USER_WORDS[32*uidx +: 32];
      end
    endcase
  end

  // Read data is muxed from pre-write state, so a combined read+write returns the old value.
  assign rdata_d = bus.read ? rd_mux : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
    end else begin
      scratch_q <= scratch_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= bus.read;
    end
  end

  assign bus.readdata      = rdata_q;
  assign bus.readdatavalid = rvalid_q;

endmodule

// File: tb/tb_sysid_regbank.sv
// Scoreboard bench for sysid_regbank; expectations follow SYSID_REGBANK_UPTIME_EN.
module tb_sysid_regbank;

  localparam int               NU = 4;
  localparam logic [32*NU-1:0] UW = {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'h1234_5678};
  localparam logic [31:0]      TS = 32'h59CB_BB80;
`ifdef SYSID_REGBANK_UPTIME_EN
  localparam bit               UP = 1'b1;
`else
  localparam bit               UP = 1'b0;
`endif
  localparam logic [31:0]      CAPS_EXP = UP ? 32'h0000_0104 : 32'h0000_0004;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] exp;
    int          src;
  } step_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [63:0] m_up;
  logic [31:0] m_hold = '0;
  logic [31:0] last = '0;

  always #5 clk = ~clk;

  sysid_regbank_if #(.ADDR_W(4)) bus ();

  sysid_regbank #(
    .NUM_USER(NU),
    .USER_WORDS(UW),
    .ADDR_W(4)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  // Reference uptime count: cleared by reset or a CONTROL bit-0 write, else +1 per edge.
  always @(posedge clk or posedge rst) begin
    if (rst) m_up <= '0;
    else if (bus.write && bus.address == 4'd6 && bus.byteenable[0] && bus.writedata[0]) m_up <= '0;
    else m_up <= m_up + 64'd1;
  end

  task automatic cyc(input step_t s);
    @(negedge clk);
    bus.read       = s.rd;
    bus.write      = s.wr;
    bus.address    = s.a;
    bus.writedata  = s.wd;
    bus.byteenable = s.be;
    if (s.rd) begin
      if (UP && s.src == 1)      exp_q.push_back(m_up[31:0]);
      else if (UP && s.src == 2) exp_q.push_back(m_hold);
      else                       exp_q.push_back(s.exp);
      if (UP && s.a == 4'd4) m_hold = m_up[63:32];
    end
    @(posedge clk);
    #1;
    bus.read  = 1'b0;
    bus.write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    bus.read = 1'b1; bus.write = 1'b0; bus.address = 4'd1; bus.writedata = '0; bus.byteenable = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_state rdv=%b data=%h required rdv=0 data=00000000", bus.readdatavalid, bus.readdata);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.read = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_pending rdv=%b required 0", bus.readdatavalid);
    end
    cyc('{1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 32'h0, 0});
    e = exp_q.pop_front();
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
      errors++;
      $display("FAIL reset_scratch rdv=%b data=%h required rdv=1 data=%h", bus.readdatavalid, bus.readdata, e);
    end
    last = e;
  endtask

  task automatic test_ids;
    logic [3:0]  addrs [10] = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9, 4'd10, 4'd11, 4'd7, 4'd12, 4'd15};
    logic [31:0] exps  [10] = '{32'h0, TS, CAPS_EXP, 32'h1234_5678, 32'hCAFE_0001, 32'hCAFE_0002,
                                32'hCAFE_0003, 32'h0, 32'h0, 32'h0};
    logic [31:0] e;
    for (int i = 0; i < 10; i++) begin
      cyc('{1'b1, 1'b0, addrs[i], 32'h0, 4'h0, exps[i], 0});
      e = exp_q.pop_front();
      checks++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
        errors++;
        $display("FAIL ids_addr%0d rdv=%b data=%h required rdv=1 data=%h", addrs[i], bus.readdatavalid, bus.readdata, e);
      end
      last = e;
    end
  endtask

  task automatic test_scratch;
    step_t t [12] = '{
      '{1'b0, 1'b1, 4'd3, 32'hAABB_CCDD, 4'b0101, 32'h0, 0},
      '{1'b1, 1'b0, 4'd3, 32'h0,         4'h0,    32'h00BB_00DD, 0},
      '{1'b0, 1'b1, 4'd3, 32'hFFFF_FFFF, 4'h0,    32'h0, 0},
      '{1'b1, 1'b0, 4'd3, 32'h0,         4'h0,    32'h00BB_00DD, 0},
      '{1'b1, 1'b1, 4'd3, 32'h1122_3344, 4'hF,    32'h00BB_00DD, 0},
      '{1'b1, 1'b0, 4'd3, 32'h0,         4'h0,    32'h1122_3344, 0},
      '{1'b0, 1'b1, 4'd0, 32'hFFFF_FFFF, 4'hF,    32'h0, 0},
      '{1'b0, 1'b1, 4'd7, 32'hFFFF_FFFF, 4'hF,    32'h0, 0},
      '{1'b0, 1'b1, 4'd8, 32'hFFFF_FFFF, 4'hF,    32'h0, 0},
      '{1'b1, 1'b0, 4'd0, 32'h0,         4'h0,    32'h0, 0},
      '{1'b1, 1'b0, 4'd7, 32'h0,         4'h0,    32'h0, 0},
      '{1'b1, 1'b0, 4'd8, 32'h0,         4'h0,    32'h1234_5678, 0}
    };
    logic [31:0] e;
    for (int i = 0; i < 12; i++) begin
      cyc(t[i]);
      checks++;
      if (t[i].rd) begin
        e = exp_q.pop_front();
        if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
          errors++;
          $display("FAIL scratch_step%0d rdv=%b data=%h required rdv=1 data=%h", i, bus.readdatavalid, bus.readdata, e);
        end
        last = e;
      end else if (bus.readdatavalid !== 1'b0 || bus.readdata !== last) begin
        errors++;
        $display("FAIL scratch_idle%0d rdv=%b data=%h required rdv=0 data=%h", i, bus.readdatavalid, bus.readdata, last);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      cyc('{1'b1, 1'b0, 4'(11 - i), 32'h0, 4'h0, UW[32*(3-i) +: 32], 0});
      e = exp_q.pop_front();
      checks++;
      if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
        errors++;
        $display("FAIL b2b_%0d rdv=%b data=%h required rdv=1 data=%h", i, bus.readdatavalid, bus.readdata, e);
      end
      last = e;
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== last) begin
      errors++;
      $display("FAIL b2b_hold rdv=%b data=%h required rdv=0 data=%h", bus.readdatavalid, bus.readdata, last);
    end
  endtask

  task automatic test_uptime;
`ifdef SYSID_REGBANK_UPTIME_EN
    step_t t [20] = '{
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h1, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 1},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 32'h0, 2},
      '{1'b0, 1'b1, 4'd6, 32'h1, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 1},
      '{1'b1, 1'b1, 4'd6, 32'h1, 4'h1, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b0, 4'd0, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h5, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h6, 0},
      '{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 32'h0, 2},
      '{1'b0, 1'b1, 4'd6, 32'h2, 4'h1, 32'h0, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 1},
      '{1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 32'h0000_0104, 0}
    };
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
`else
    step_t t [6] = '{
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd6, 32'h0, 4'h0, 32'h0, 0},
      '{1'b0, 1'b1, 4'd4, 32'hFFFF_FFFF, 4'hF, 32'h0, 0},
      '{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'h0, 0},
      '{1'b1, 1'b0, 4'd2, 32'h0, 4'h0, 32'h0000_0004, 0}
    };
`endif
    logic [31:0] e;
    foreach (t[i]) begin
      cyc(t[i]);
      if (t[i].rd) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
          errors++;
          $display("FAIL uptime_step%0d rdv=%b data=%h required rdv=1 data=%h", i, bus.readdatavalid, bus.readdata, e);
        end
        last = e;
      end
    end
  endtask

  task automatic test_snapshot;
`ifdef SYSID_REGBANK_UPTIME_EN
    logic [31:0] e;
    @(negedge clk);
    force dut.uptime_q = 64'h0000_0001_FFFF_FFFE;
    #1;
    release dut.uptime_q;
    cyc('{1'b1, 1'b0, 4'd4, 32'h0, 4'h0, 32'hFFFF_FFFF, 0});
    e = exp_q.pop_front();
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
      errors++;
      $display("FAIL snap_lo rdv=%b data=%h required rdv=1 data=%h", bus.readdatavalid, bus.readdata, e);
    end
    repeat (9) @(posedge clk);
    cyc('{1'b1, 1'b0, 4'd5, 32'h0, 4'h0, 32'h0000_0001, 0});
    e = exp_q.pop_front();
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
      errors++;
      $display("FAIL snap_hi rdv=%b data=%h required rdv=1 data=%h", bus.readdatavalid, bus.readdata, e);
    end
    last = e;
`endif
  endtask

  task automatic test_async_reset;
    logic [31:0] e;
    cyc('{1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 4'hF, 32'h0, 0});
    cyc('{1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 32'hDEAD_BEEF, 0});
    e = exp_q.pop_front();
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
      errors++;
      $display("FAIL areset_inflight rdv=%b data=%h required rdv=1 data=%h", bus.readdatavalid, bus.readdata, e);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0 || bus.readdata !== 32'h0) begin
      errors++;
      $display("FAIL areset_immediate rdv=%b data=%h required rdv=0 data=00000000", bus.readdatavalid, bus.readdata);
    end
    bus.read = 1'b1;
    bus.address = 4'd1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.read = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.readdatavalid !== 1'b0) begin
      errors++;
      $display("FAIL areset_no_pending rdv=%b required 0", bus.readdatavalid);
    end
    cyc('{1'b1, 1'b0, 4'd3, 32'h0, 4'h0, 32'h0, 0});
    e = exp_q.pop_front();
    checks++;
    if (bus.readdatavalid !== 1'b1 || bus.readdata !== e) begin
      errors++;
      $display("FAIL areset_scratch rdv=%b data=%h required rdv=1 data=%h", bus.readdatavalid, bus.readdata, e);
    end
  endtask

  initial begin
    test_reset();
    test_ids();
    test_scratch();
    test_back_to_back();
    test_uptime();
    test_snapshot();
    test_async_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
